// File: rtl/hybrid_adder_if.sv
// Operand/result bundle for hybrid_adder.
// master drives A/B and reads sum/cout; slave is the adder side.
interface hybrid_adder_if #(
  parameter int W = 32
);
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] sum;
  logic         cout;

  modport master (
    output A,
    output B,
    input  sum,
    input  cout
  );

  modport slave (
    input  A,
    input  B,
    output sum,
    output cout
  );
endinterface

// File: rtl/hybrid_adder.sv
// Registered approximate/exact hybrid adder-subtractor.
// Ports: clk, rst (async high), bus.A/bus.B operands, bus.sum/bus.cout result.
module hybrid_adder #(
  parameter int N1       = 16,
  parameter int N2       = 16,
  parameter bit addOrSub = 1'b1
) (
  input logic          clk,
  input logic          rst,
  hybrid_adder_if.slave bus
);
  localparam int W = N1 + N2;

  logic [W-1:0] beff;
  logic [W-1:0] next_sum;
  logic         next_cout;
  logic [W-1:0] sum_q;
  logic         cout_q;

  // Subtract is A + ~B + 1.
  assign beff = addOrSub ? bus.B : ~bus.B;

  // Ripple chain. The carry is exact majority in every bit,
  // so approximation never leaks above bit N1-1.
  always_comb begin
    logic c;
    logic cn;
    logic a;
    logic b;
    next_sum = '0;
    c        = ~addOrSub;
    for (int i = 0; i < W; i++) begin
      a  = bus.A[i];
      b  = beff[i];
      cn = (a & b) | (a & c) | (b & c);
      if (i < N1)
        // Drops the sum bit only when a=b=c=1.
        next_sum[i] = (a | b | c) & ~cn;
      else
        next_sum[i] = a ^ b ^ c;
      c = cn;
    end
    next_cout = c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= next_sum;
      cout_q <= next_cout;
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_hybrid_adder.sv
// Self-checking bench for hybrid_adder.
// Add and subtract instances share operands; a queue scoreboard checks each.
module tb_hybrid_adder;
  typedef struct packed {
    logic [31:0] s;
    logic        c;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   failed = 0;
  res_t qa[$];
  res_t qs[$];

  hybrid_adder_if #(.W(32)) add_if ();
  hybrid_adder_if #(.W(32)) sub_if ();

  hybrid_adder #(.N1(16), .N2(16), .addOrSub(1'b1)) u_add (
    .clk (clk),
    .rst (rst),
    .bus (add_if)
  );

  hybrid_adder #(.N1(16), .N2(16), .addOrSub(1'b0)) u_sub (
    .clk (clk),
    .rst (rst),
    .bus (sub_if)
  );

  always #5 clk = ~clk;

  // Exact sum, then clear every low bit whose a, b and carry-in are all 1.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input bit sub);
    res_t        r;
    logic [31:0] be;
    logic [32:0] ex;
    logic [31:0] cin;
    logic [31:0] m;
    be   = sub ? ~b : b;
    ex   = {1'b0, a} + {1'b0, be} + {32'd0, sub};
    cin  = ex[31:0] ^ a ^ be;
    m    = a & be & cin & 32'h0000_FFFF;
    r.s  = ex[31:0] - m;
    r.c  = ex[32];
    return r;
  endfunction

  function automatic logic [31:0] exact(input logic [31:0] a,
                                        input logic [31:0] b, input bit sub);
    return sub ? a - b : a + b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b);
    add_if.A = a;
    add_if.B = b;
    sub_if.A = a;
    sub_if.B = b;
  endtask

  // Drive at negedge, push expectations, compare just after the next edge.
  task automatic step(input logic [31:0] a, input logic [31:0] b);
    res_t e;
    @(negedge clk);
    drive(a, b);
    qa.push_back(model(a, b, 1'b0));
    qs.push_back(model(a, b, 1'b1));
    @(posedge clk);
    #1;
    e = qa.pop_front();
    chk("add_sum", add_if.sum, e.s);
    chk("add_cout", {31'd0, add_if.cout}, {31'd0, e.c});
    e = qs.pop_front();
    chk("sub_sum", sub_if.sum, e.s);
    chk("sub_cout", {31'd0, sub_if.cout}, {31'd0, e.c});
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] held;

    drive($urandom, $urandom);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_sum", add_if.sum, 32'd0);
    chk("rst_async_cout", {31'd0, add_if.cout}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_sum", add_if.sum, 32'd0);
    chk("rst_hold_subsum", sub_if.sum, 32'd0);
    chk("rst_hold_cout", {31'd0, sub_if.cout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    step(32'h0000_0001, 32'h0000_0001);
    chk("add_1p1", add_if.sum, 32'h0000_0002);
    chk("add_1p1_c", {31'd0, add_if.cout}, 32'd0);
    step(32'h0000_0003, 32'h0000_0001);
    chk("add_3p1", add_if.sum, 32'h0000_0004);
    step(32'h0000_0003, 32'h0000_0003);
    chk("add_3p3_approx", add_if.sum, 32'h0000_0004);
    chk("add_3p3_c", {31'd0, add_if.cout}, 32'd0);
    step(32'h0001_0000, 32'h0003_0000);
    chk("add_high", add_if.sum, 32'h0004_0000);
    chk("add_high_c", {31'd0, add_if.cout}, 32'd0);
    step(32'hFFFF_0000, 32'h0001_0000);
    chk("add_ovf", add_if.sum, 32'h0000_0000);
    chk("add_ovf_c", {31'd0, add_if.cout}, 32'd1);
    step(32'h0000_0005, 32'h0000_0003);
    chk("sub_5m3", sub_if.sum, 32'h0000_0002);
    chk("sub_5m3_c", {31'd0, sub_if.cout}, 32'd1);
    step(32'h0000_0000, 32'h0000_0000);
    chk("sub_0m0", sub_if.sum, 32'h0000_0000);
    chk("sub_0m0_c", {31'd0, sub_if.cout}, 32'd1);
    step(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step(32'h0000_0000, 32'h0000_0001);
    chk("sub_borrow_c", {31'd0, sub_if.cout}, 32'd0);

    // Mid-cycle operand change must not reach the outputs.
    held = add_if.sum;
    #2 drive(32'h1234_5678, 32'h0F0F_0F0F);
    #2;
    chk("hold_between_edges", add_if.sum, held);

    // Async reset mid-cycle with a non-zero result in flight.
    step(32'h0000_00F0, 32'h0000_0F00);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_sum", add_if.sum, 32'd0);
    chk("rst_mid_subsum", sub_if.sum, 32'd0);
    chk("rst_mid_subc", {31'd0, sub_if.cout}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_mid_edge", sub_if.sum, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 1200; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 7 == 0) rb = ra;
      step(ra, rb);
      chk("add_err_range",
          {31'd0, (exact(ra, rb, 1'b0) - add_if.sum) <= 32'h0000_FFFF},
          32'd1);
      chk("sub_err_range",
          {31'd0, (exact(ra, rb, 1'b1) - sub_if.sum) <= 32'h0000_FFFF},
          32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
